// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer slice.
// The release FSM walks HOLD -> RELEASE -> RUN. Soft reset returns it to RELEASE.
package rst_seq_pkg;

  // Reset release sequencer states.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,  // waiting for the synchronised reset to drop
    RELEASE = 2'd1,  // staggering channel releases GAP cycles apart
    RUN     = 2'd2   // all channels released
  } seq_state_e;

  // Width of the inter-release gap counter.
  // The extra bit keeps GAP=1 legal, because $clog2(1)=0.
  function automatic int cnt_width(input int gap);
    return $clog2(gap) + 1;
  endfunction

  // Width of the channel index.
  // The index can reach NUM_CH after the last release without wrapping.
  function automatic int idx_width(input int num_ch);
    return $clog2(num_ch) + 1;
  endfunction

  // Widths for the default configuration (GAP=4, NUM_CH=4).
  localparam int DEF_CNT_W = 3;
  localparam int DEF_IDX_W = 3;

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser.
// Asserts asynchronously and deasserts synchronously.
// rst_s drops after SYNC_STAGES rising edges once rst has fallen.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_s
);

  logic [SYNC_STAGES-1:0] chain;

  // Fill the chain with ones on reset, then shift zeros in from the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sync_seq_reg.sv
// NUM_CH x WIDTH data registers behind one reset front end.
// The front end has three parts:
//   - an async-assert / sync-deassert synchroniser;
//   - a synchronous soft reset;
//   - a staggered per-channel release sequencer.
// Optional output done_pulse is built only when RSTSEQ_DONE_PULSE_EN is defined.
// ready and ch_rst are plain status levels, not a handshake.
// ready=1 means every channel has been released.
// Internal FSM state is visible as "state" (seq_state_e) for checkers.
module rst_sync_seq_reg
  import rst_seq_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NUM_CH      = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               GAP         = 4,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    srst,
  input  logic [NUM_CH*WIDTH-1:0] d,
  input  logic [NUM_CH-1:0]       en,
  output logic [NUM_CH*WIDTH-1:0] q,
  output logic [NUM_CH-1:0]       ch_rst,
  output logic                    ready
`ifdef RSTSEQ_DONE_PULSE_EN
  ,
  output logic                    done_pulse
`endif
);

  localparam int               CNT_W    = cnt_width(GAP);
  localparam int               IDX_W    = idx_width(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  logic rst_s;

  seq_state_e        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [NUM_CH-1:0] ch_rst_next;
  logic              soft_hit;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk  (clk),
    .rst  (rst),
    .rst_s(rst_s)
  );

  // Sequencer state registers.
  // They reset on the raw async rst, so outputs clear without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HOLD;
      cnt    <= '0;
      idx    <= '0;
      ch_rst <= '1;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      idx    <= idx_next;
      ch_rst <= ch_rst_next;
    end
  end

  // Next-state logic. A soft reset overrides any release on the same edge.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    idx_next    = idx;
    ch_rst_next = ch_rst;
    soft_hit    = 1'b0;

    unique case (state)
      HOLD: begin
        if (!rst_s) begin
          state_next = RELEASE;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      RELEASE: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          idx_next = idx + IDX_W'(1);
          for (int k = 0; k < NUM_CH; k++) begin
            if (idx == IDX_W'(k)) begin
              ch_rst_next[k] = 1'b0;
            end
          end
          if (idx == IDX_LAST) begin
            state_next = RUN;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = HOLD;
      end
    endcase

    // Soft reset restarts the stagger.
    // It does not rerun the synchroniser, and it is ignored while still in HOLD.
    if (srst && (state != HOLD)) begin
      soft_hit    = 1'b1;
      state_next  = RELEASE;
      cnt_next    = '0;
      idx_next    = '0;
      ch_rst_next = '1;
    end
  end

  assign ready = (state == RUN);

  // Channel data registers.
  // The registered ch_rst gates loads, so the first load lands one edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {NUM_CH{RST_VAL}};
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (soft_hit || ch_rst[k]) begin
          q[k*WIDTH +: WIDTH] <= RST_VAL;
        end else if (en[k]) begin
          q[k*WIDTH +: WIDTH] <= d[k*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef RSTSEQ_DONE_PULSE_EN
  // One-cycle pulse on the edge where ready rises.
  // This includes the rise after a soft reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= (state_next == RUN) && (state != RUN);
    end
  end
`endif

endmodule

// File: tb/tb_rst_sync_seq_reg.sv
// Directed bench for rst_sync_seq_reg with the default parameters.
// Edge numbers count rising clk edges after rst deassertion.
// Set RSTSEQ_DONE_PULSE_EN to also check done_pulse.
module tb_rst_sync_seq_reg;

  logic        clk;
  logic        rst;
  logic        srst;
  logic [31:0] d;
  logic [3:0]  en;
  logic [31:0] q;
  logic [3:0]  ch_rst;
  logic        ready;
`ifdef RSTSEQ_DONE_PULSE_EN
  logic        done_pulse;
`endif

  int vectors;
  int miscompares;

  rst_sync_seq_reg #(
    .WIDTH      (8),
    .NUM_CH     (4),
    .SYNC_STAGES(2),
    .GAP        (4),
    .RST_VAL    (8'h00)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .srst  (srst),
    .d     (d),
    .en    (en),
    .q     (q),
    .ch_rst(ch_rst),
    .ready (ready)
`ifdef RSTSEQ_DONE_PULSE_EN
    ,
    .done_pulse(done_pulse)
`endif
  );

  // Clock and reset: 10 ns period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold rst for 3 edges, then release it mid-cycle.
  task automatic apply_rst();
    rst = 1'b1;
    repeat (3) step();
    #3;
    rst = 1'b0;
  endtask

  // Expected ch_rst at edge n.
  // Channel k is released at edge first + 4*k.
  function automatic logic [3:0] exp_ch_rst(input int n, input int first);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (n < first + 4 * k);
    return r;
  endfunction

  // Expected q when en=1111 and d=FFFFFFFF during a power-up sequence.
  // Channel k loads one edge after its release.
  function automatic logic [31:0] exp_gated_q(input int n);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = (n >= 8 + 4 * k) ? 8'hFF : 8'h00;
    return r;
  endfunction

  task automatic test_reset();
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (q !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_q got %h exp %h", q, 32'h0);
    end
    vectors++;
    if (ch_rst !== 4'b1111) begin
      miscompares++;
      $display("FAIL reset_ch_rst got %b exp %b", ch_rst, 4'b1111);
    end
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready got %b exp 0", ready);
    end
  endtask

  task automatic test_power_up();
    en   = 4'b0000;
    d    = 32'h0;
    srst = 1'b0;
    apply_rst();
    for (int n = 1; n <= 20; n++) begin
      step();
      vectors++;
      if (ch_rst !== exp_ch_rst(n, 7)) begin
        miscompares++;
        $display("FAIL power_up_ch_rst edge %0d got %b exp %b", n, ch_rst, exp_ch_rst(n, 7));
      end
      vectors++;
      if (ready !== (n >= 19)) begin
        miscompares++;
        $display("FAIL power_up_ready edge %0d got %b exp %b", n, ready, (n >= 19));
      end
      vectors++;
      if (q !== 32'h0) begin
        miscompares++;
        $display("FAIL power_up_q edge %0d got %h exp 0", n, q);
      end
`ifdef RSTSEQ_DONE_PULSE_EN
      vectors++;
      if (done_pulse !== (n == 19)) begin
        miscompares++;
        $display("FAIL power_up_done edge %0d got %b exp %b", n, done_pulse, (n == 19));
      end
`endif
    end
  endtask

  task automatic test_load();
    en = 4'b0101;
    d  = 32'hA1B2C3D4;
    step();
    vectors++;
    if (q !== 32'h00B200D4) begin
      miscompares++;
      $display("FAIL load_0101 got %h exp %h", q, 32'h00B200D4);
    end

    en = 4'b0000;
    d  = 32'h55555555;
    step();
    vectors++;
    if (q !== 32'h00B200D4) begin
      miscompares++;
      $display("FAIL load_hold got %h exp %h", q, 32'h00B200D4);
    end

    en = 4'b1010;
    d  = 32'h11223344;
    step();
    vectors++;
    if (q !== 32'h11B233D4) begin
      miscompares++;
      $display("FAIL load_1010 got %h exp %h", q, 32'h11B233D4);
    end

    en = 4'b1111;
    d  = 32'hDEADBEEF;
    step();
    vectors++;
    if (q !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL load_all got %h exp %h", q, 32'hDEADBEEF);
    end
    en = 4'b0000;
  endtask

  task automatic test_srst_run();
    srst = 1'b1;
    for (int s = 1; s <= 2; s++) begin
      step();
      vectors++;
      if (q !== 32'h0) begin
        miscompares++;
        $display("FAIL srst_q edge %0d got %h exp 0", s, q);
      end
      vectors++;
      if (ch_rst !== 4'b1111) begin
        miscompares++;
        $display("FAIL srst_ch_rst edge %0d got %b exp 1111", s, ch_rst);
      end
      vectors++;
      if (ready !== 1'b0) begin
        miscompares++;
        $display("FAIL srst_ready edge %0d got %b exp 0", s, ready);
      end
    end
    srst = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      step();
      vectors++;
      if (ch_rst !== exp_ch_rst(n, 4)) begin
        miscompares++;
        $display("FAIL srst_release_ch_rst edge %0d got %b exp %b", n, ch_rst, exp_ch_rst(n, 4));
      end
      vectors++;
      if (ready !== (n >= 16)) begin
        miscompares++;
        $display("FAIL srst_release_ready edge %0d got %b exp %b", n, ready, (n >= 16));
      end
`ifdef RSTSEQ_DONE_PULSE_EN
      vectors++;
      if (done_pulse !== (n == 16)) begin
        miscompares++;
        $display("FAIL srst_done edge %0d got %b exp %b", n, done_pulse, (n == 16));
      end
`endif
    end
  endtask

  // The soft reset lands on the same edge as ch1's release, and the soft reset must win.
  task automatic test_srst_collision();
    srst = 1'b1;
    step();
    srst = 1'b0;
    repeat (7) step();
    srst = 1'b1;
    step();
    vectors++;
    if (ch_rst !== 4'b1111) begin
      miscompares++;
      $display("FAIL collision_ch_rst got %b exp 1111", ch_rst);
    end
    srst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      step();
      vectors++;
      if (ch_rst !== exp_ch_rst(n, 4)) begin
        miscompares++;
        $display("FAIL collision_release edge %0d got %b exp %b", n, ch_rst, exp_ch_rst(n, 4));
      end
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_ready got %b exp 1", ready);
    end
  endtask

  // A soft reset asserted while still in HOLD, through edge 3, must not shift the timing.
  task automatic test_srst_hold();
    apply_rst();
    for (int n = 1; n <= 19; n++) begin
      srst = (n <= 3);
      step();
      vectors++;
      if (ch_rst !== exp_ch_rst(n, 7)) begin
        miscompares++;
        $display("FAIL srst_hold_ch_rst edge %0d got %b exp %b", n, ch_rst, exp_ch_rst(n, 7));
      end
    end
    srst = 1'b0;
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL srst_hold_ready got %b exp 1", ready);
    end
  endtask

  task automatic test_gated_load();
    en = 4'b1111;
    d  = 32'hFFFFFFFF;
    apply_rst();
    for (int n = 1; n <= 20; n++) begin
      step();
      vectors++;
      if (q !== exp_gated_q(n)) begin
        miscompares++;
        $display("FAIL gated_load_q edge %0d got %h exp %h", n, q, exp_gated_q(n));
      end
    end
  endtask

  task automatic test_async_glitch();
    en = 4'b1111;
    d  = 32'hFFFFFFFF;
    apply_rst();
    repeat (9) step();
    vectors++;
    if (q !== 32'h000000FF) begin
      miscompares++;
      $display("FAIL glitch_pre_q got %h exp %h", q, 32'h000000FF);
    end
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (q !== 32'h0) begin
      miscompares++;
      $display("FAIL glitch_q got %h exp 0", q);
    end
    vectors++;
    if (ch_rst !== 4'b1111) begin
      miscompares++;
      $display("FAIL glitch_ch_rst got %b exp 1111", ch_rst);
    end
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_ready got %b exp 0", ready);
    end
    for (int n = 1; n <= 20; n++) begin
      step();
      vectors++;
      if (ch_rst !== exp_ch_rst(n, 7)) begin
        miscompares++;
        $display("FAIL glitch_restart_ch_rst edge %0d got %b exp %b", n, ch_rst, exp_ch_rst(n, 7));
      end
      vectors++;
      if (q !== exp_gated_q(n)) begin
        miscompares++;
        $display("FAIL glitch_restart_q edge %0d got %h exp %h", n, q, exp_gated_q(n));
      end
      vectors++;
      if (ready !== (n >= 19)) begin
        miscompares++;
        $display("FAIL glitch_restart_ready edge %0d got %b exp %b", n, ready, (n >= 19));
      end
    end
    en = 4'b0000;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    srst        = 1'b0;
    en          = 4'b0000;
    d           = 32'h0;
    test_reset();
    test_power_up();
    test_load();
    test_srst_run();
    test_srst_collision();
    test_srst_hold();
    test_gated_load();
    test_async_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
